// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe board select controller: grid geometry,
// FSM states, colour and winner codes, and the eight winning-line masks.
package ttt_pkg;

    localparam int COORD_W = 12;
    localparam int IDX_W   = 4;
    localparam int NUM_SQ  = 9;

    // Inclusive pixel bounds of the three grid columns and rows.
    localparam logic [COORD_W-1:0] COL0_LO = 12'd8;
    localparam logic [COORD_W-1:0] COL0_HI = 12'd343;
    localparam logic [COORD_W-1:0] COL1_LO = 12'd344;
    localparam logic [COORD_W-1:0] COL1_HI = 12'd679;
    localparam logic [COORD_W-1:0] COL2_LO = 12'd680;
    localparam logic [COORD_W-1:0] COL2_HI = 12'd1015;
    localparam logic [COORD_W-1:0] ROW0_LO = 12'd10;
    localparam logic [COORD_W-1:0] ROW0_HI = 12'd258;
    localparam logic [COORD_W-1:0] ROW1_LO = 12'd259;
    localparam logic [COORD_W-1:0] ROW1_HI = 12'd507;
    localparam logic [COORD_W-1:0] ROW2_LO = 12'd508;
    localparam logic [COORD_W-1:0] ROW2_HI = 12'd756;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_PRESS,
        ST_DECODE,
        ST_COMMIT,
        ST_WAIT_RELEASE
    } state_e;

    typedef enum logic {
        COLOR_BLUE   = 1'b0,
        COLOR_YELLOW = 1'b1
    } color_e;

    typedef enum logic [1:0] {
        WIN_NONE   = 2'b00,
        WIN_BLUE   = 2'b01,
        WIN_YELLOW = 2'b10,
        WIN_DRAW   = 2'b11
    } winner_e;

    // Bit i of a mask stands for square i+1: rows, then columns, then diagonals.
    function automatic logic [NUM_SQ-1:0] win_line(input int unsigned k);
        case (k)
            0:       win_line = 9'h007;
            1:       win_line = 9'h038;
            2:       win_line = 9'h1C0;
            3:       win_line = 9'h049;
            4:       win_line = 9'h092;
            5:       win_line = 9'h124;
            6:       win_line = 9'h111;
            default: win_line = 9'h054;
        endcase
    endfunction

endpackage

// File: rtl/board_select_ctl_if.sv
// Mouse, game-control and board-state signals exchanged with board_select_ctl.
// master = the surrounding game logic, slave = the controller.
interface board_select_ctl_if;
    import ttt_pkg::*;

    logic [COORD_W-1:0] mouse_xpos;
    logic [COORD_W-1:0] mouse_ypos;
    logic               mouse_left;
    logic               start_en;
    logic               choice_en;
    logic               new_game;
    logic [NUM_SQ-1:0]  square;
    logic [NUM_SQ-1:0]  square_color;
    logic               turn;
    logic               move_valid;
    logic [IDX_W-1:0]   move_idx;
    logic               game_over;
    logic [1:0]         winner;

    modport master (
        output mouse_xpos, mouse_ypos, mouse_left, start_en, choice_en, new_game,
        input  square, square_color, turn, move_valid, move_idx, game_over, winner
    );

    modport slave (
        input  mouse_xpos, mouse_ypos, mouse_left, start_en, choice_en, new_game,
        output square, square_color, turn, move_valid, move_idx, game_over, winner
    );

endinterface

// File: rtl/board_select_ctl_square_decode.sv
// Combinational cursor-to-square decode: returns 1..9 (row*3 + col + 1) for a hit
// inside the grid, 0 for a miss.
module square_decode
    import ttt_pkg::*;
(
    input  logic [COORD_W-1:0] xpos,
    input  logic [COORD_W-1:0] ypos,
    output logic [IDX_W-1:0]   idx
);

    logic [1:0] col;
    logic [1:0] row;
    logic       hit_x;
    logic       hit_y;

    // NOTE: every output of this block is given a default first so no path can infer a latch.
    always_comb begin
        col   = 2'd0;
        row   = 2'd0;
        hit_x = 1'b1;
        hit_y = 1'b1;
        idx   = '0;

        if (xpos >= COL0_LO && xpos <= COL0_HI)      col = 2'd0;
        else if (xpos >= COL1_LO && xpos <= COL1_HI) col = 2'd1;
        else if (xpos >= COL2_LO && xpos <= COL2_HI) col = 2'd2;
        else                                          hit_x = 1'b0;

        if (ypos >= ROW0_LO && ypos <= ROW0_HI)      row = 2'd0;
        else if (ypos >= ROW1_LO && ypos <= ROW1_HI) row = 2'd1;
        else if (ypos >= ROW2_LO && ypos <= ROW2_HI) row = 2'd2;
        else                                          hit_y = 1'b0;

        if (hit_x && hit_y)
            idx = {2'b00, row} * 4'd3 + {2'b00, col} + 4'd1;
    end

endmodule

// File: rtl/board_select_ctl.sv
// Mouse-driven square selection for the tic-tac-toe board. Define BOARD_WIN_DETECT_EN
// to add three-in-a-row detection; otherwise only a full board ends the game (draw).
module board_select_ctl
    import ttt_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic               pclk,
    input  logic               rst,
    board_select_ctl_if.slave  bus
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   btn_prev_q, btn_prev_d;
    state_e                 state_q, state_d;
    logic [COORD_W-1:0]     xpos_q, xpos_d;
    logic [COORD_W-1:0]     ypos_q, ypos_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [NUM_SQ-1:0]      square_q, square_d;
    logic [NUM_SQ-1:0]      color_q, color_d;
    color_e                 turn_q, turn_d;
    logic                   move_valid_q, move_valid_d;
    logic [IDX_W-1:0]       move_idx_q, move_idx_d;
    logic                   game_over_q, game_over_d;
    winner_e                winner_q, winner_d;
    logic                   chk_q, chk_d;

    logic                   btn_s;
    logic                   press;
    logic                   run_ok;
    logic [IDX_W-1:0]       dec_idx;
    logic                   win_blue;
    logic                   win_yellow;

    assign btn_s  = sync_q[SYNC_STAGES-1];
    assign press  = btn_s & ~btn_prev_q;
    assign run_ok = bus.start_en & ~bus.choice_en & ~game_over_q;

    square_decode u_decode (
        .xpos (xpos_q),
        .ypos (ypos_q),
        .idx  (dec_idx)
    );

`ifdef BOARD_WIN_DETECT_EN
    always_comb begin
        win_blue   = 1'b0;
        win_yellow = 1'b0;
        for (int unsigned k = 0; k < 8; k++) begin
            if ((square_q & win_line(k)) == win_line(k)) begin
                if ((color_q & win_line(k)) == win_line(k)) win_yellow = 1'b1;
                else if ((color_q & win_line(k)) == '0)     win_blue   = 1'b1;
            end
        end
    end
`else
    assign win_blue   = 1'b0;
    assign win_yellow = 1'b0;
`endif

    always_comb begin
        sync_d       = {sync_q[SYNC_STAGES-2:0], bus.mouse_left};
        btn_prev_d   = btn_s;
        state_d      = state_q;
        xpos_d       = xpos_q;
        ypos_d       = ypos_q;
        idx_d        = idx_q;
        square_d     = square_q;
        color_d      = color_q;
        turn_d       = turn_q;
        move_valid_d = 1'b0;
        move_idx_d   = move_idx_q;
        game_over_d  = game_over_q;
        winner_d     = winner_q;
        chk_d        = 1'b0;

        // The board is judged in the cycle after a commit, once it holds the new move.
        if (chk_q) begin
            if (win_blue) begin
                game_over_d = 1'b1;
                winner_d    = WIN_BLUE;
            end else if (win_yellow) begin
                game_over_d = 1'b1;
                winner_d    = WIN_YELLOW;
            end else if (&square_q) begin
                game_over_d = 1'b1;
                winner_d    = WIN_DRAW;
            end
        end

        if (!run_ok) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:       state_d = ST_WAIT_PRESS;
                ST_WAIT_PRESS: begin
                    if (press) begin
                        xpos_d  = bus.mouse_xpos;
                        ypos_d  = bus.mouse_ypos;
                        state_d = ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    idx_d = dec_idx;
                    if (dec_idx != '0 && !square_q[dec_idx - 4'd1]) state_d = ST_COMMIT;
                    else                                            state_d = ST_WAIT_RELEASE;
                end
                ST_COMMIT: begin
                    square_d[idx_q - 4'd1] = 1'b1;
                    color_d[idx_q - 4'd1]  = turn_q;
                    turn_d       = (turn_q == COLOR_BLUE) ? COLOR_YELLOW : COLOR_BLUE;
                    move_idx_d   = idx_q;
                    move_valid_d = 1'b1;
                    chk_d        = 1'b1;
                    state_d      = ST_WAIT_RELEASE;
                end
                ST_WAIT_RELEASE: if (!btn_s) state_d = ST_WAIT_PRESS;
                default:         state_d = ST_IDLE;
            endcase
        end

        // Board clear overrides everything, including a commit landing this cycle.
        if (bus.new_game) begin
            square_d     = '0;
            color_d      = '0;
            turn_d       = COLOR_BLUE;
            move_idx_d   = '0;
            move_valid_d = 1'b0;
            game_over_d  = 1'b0;
            winner_d     = WIN_NONE;
            chk_d        = 1'b0;
            state_d      = ST_IDLE;
        end
    end

    // NOTE: state uses non-blocking assignments only, and every flop is reset so an
    // in-flight decode or commit is dropped cleanly.
    always_ff @(posedge pclk) begin
        if (rst) begin
            sync_q       <= '0;
            btn_prev_q   <= 1'b0;
            state_q      <= ST_IDLE;
            xpos_q       <= '0;
            ypos_q       <= '0;
            idx_q        <= '0;
            square_q     <= '0;
            color_q      <= '0;
            turn_q       <= COLOR_BLUE;
            move_valid_q <= 1'b0;
            move_idx_q   <= '0;
            game_over_q  <= 1'b0;
            winner_q     <= WIN_NONE;
            chk_q        <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            btn_prev_q   <= btn_prev_d;
            state_q      <= state_d;
            xpos_q       <= xpos_d;
            ypos_q       <= ypos_d;
            idx_q        <= idx_d;
            square_q     <= square_d;
            color_q      <= color_d;
            turn_q       <= turn_d;
            move_valid_q <= move_valid_d;
            move_idx_q   <= move_idx_d;
            game_over_q  <= game_over_d;
            winner_q     <= winner_d;
            chk_q        <= chk_d;
        end
    end

    assign bus.square       = square_q;
    assign bus.square_color = color_q;
    assign bus.turn         = turn_q;
    assign bus.move_valid   = move_valid_q;
    assign bus.move_idx     = move_idx_q;
    assign bus.game_over    = game_over_q;
    assign bus.winner       = winner_q;

endmodule

// File: tb/tb_board_select_ctl.sv
// Directed bench for board_select_ctl: expected moves are queued when a click is
// driven and popped when move_valid is seen. Honours BOARD_WIN_DETECT_EN.
module tb_board_select_ctl;
    import ttt_pkg::*;

    typedef struct packed {
        logic [3:0] idx;
        logic       color;
    } move_t;

    logic pclk = 1'b0;
    logic rst;

    board_select_ctl_if bus ();

    board_select_ctl #(.SYNC_STAGES(2)) dut (
        .pclk (pclk),
        .rst  (rst),
        .bus  (bus)
    );

    always #5 pclk = ~pclk;

    int          n_cmp = 0;
    int          n_bad = 0;
    move_t       exp_q[$];
    logic [8:0]  exp_sq  = '0;
    logic [8:0]  exp_col = '0;
    logic        exp_turn = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge pclk);
    endtask

    function automatic logic [11:0] sq_x(input int idx);
        case ((idx - 1) % 3)
            0:       sq_x = 12'd100;
            1:       sq_x = 12'd500;
            default: sq_x = 12'd800;
        endcase
    endfunction

    function automatic logic [11:0] sq_y(input int idx);
        case ((idx - 1) / 3)
            0:       sq_y = 12'd100;
            1:       sq_y = 12'd400;
            default: sq_y = 12'd600;
        endcase
    endfunction

    // Press at (x,y), hold for max(hold,8) cycles, then release. A committed move
    // must pulse move_valid for one cycle on the 5th negedge after the press
    // (2 sync flops + detection edge + decode + commit).
    task automatic click(input logic [11:0] x, input logic [11:0] y,
                         input bit expect_move, input logic [3:0] exp_idx, input int hold);
        int    pulses;
        int    first;
        int    win;
        move_t m;
        pulses = 0;
        first  = 0;
        win    = (hold > 8) ? hold : 8;
        bus.mouse_xpos = x;
        bus.mouse_ypos = y;
        bus.mouse_left = 1'b1;
        if (expect_move) exp_q.push_back('{idx: exp_idx, color: exp_turn});
        for (int n = 1; n <= win; n++) begin
            @(negedge pclk);
            if (bus.move_valid === 1'b1) begin
                pulses++;
                if (first == 0) first = n;
                if (exp_q.size() > 0) begin
                    m = exp_q.pop_front();
                    check("move_idx", bus.move_idx, m.idx);
                    check("move_color", bus.square_color[m.idx - 4'd1], m.color);
                    exp_sq[m.idx - 4'd1]  = 1'b1;
                    exp_col[m.idx - 4'd1] = m.color;
                    exp_turn = ~exp_turn;
                end
            end
        end
        check("move_pulses", pulses, expect_move ? 1 : 0);
        if (expect_move) check("move_latency", first, 5);
        exp_q.delete();
        check("square", bus.square, exp_sq);
        check("square_color", bus.square_color, exp_col);
        check("turn", bus.turn, exp_turn);
        bus.mouse_left = 1'b0;
        tick(4);
    endtask

    task automatic move(input int idx);
        click(sq_x(idx), sq_y(idx), 1'b1, 4'(idx), 0);
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_square"}, bus.square, 9'h000);
        check({tag, "_color"}, bus.square_color, 9'h000);
        check({tag, "_turn"}, bus.turn, 1'b0);
        check({tag, "_move_valid"}, bus.move_valid, 1'b0);
        check({tag, "_move_idx"}, bus.move_idx, 4'd0);
        check({tag, "_game_over"}, bus.game_over, 1'b0);
        check({tag, "_winner"}, bus.winner, 2'b00);
    endtask

    task automatic pulse_new_game();
        bus.new_game = 1'b1;
        tick(1);
        bus.new_game = 1'b0;
        exp_sq = '0; exp_col = '0; exp_turn = 1'b0;
        check_cleared("new_game");
        tick(2);
    endtask

    initial begin
        rst            = 1'b1;
        bus.mouse_xpos = '0;
        bus.mouse_ypos = '0;
        bus.mouse_left = 1'b0;
        bus.start_en   = 1'b0;
        bus.choice_en  = 1'b0;
        bus.new_game   = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(1);
        check_cleared("reset");

        bus.start_en = 1'b1;
        tick(2);

        // Centre click, repeat on an occupied square, grid-edge pixels, off-grid click.
        click(12'd500, 12'd400, 1'b1, 4'd5, 0);
        click(12'd500, 12'd400, 1'b0, 4'd0, 0);
        click(12'd343, 12'd258, 1'b1, 4'd1, 0);
        click(12'd1016, 12'd400, 1'b0, 4'd0, 0);

        // Menu open: clicks are ignored.
        bus.choice_en = 1'b1;
        click(12'd800, 12'd600, 1'b0, 4'd0, 0);
        bus.choice_en = 1'b0;
        tick(2);

        // Held button produces exactly one move.
        click(12'd800, 12'd600, 1'b1, 4'd9, 1000);

        // new_game during the COMMIT cycle beats the commit.
        bus.mouse_xpos = 12'd500;
        bus.mouse_ypos = 12'd100;
        bus.mouse_left = 1'b1;
        tick(4);
        bus.new_game = 1'b1;
        tick(1);
        bus.new_game = 1'b0;
        exp_sq = '0; exp_col = '0; exp_turn = 1'b0;
        check_cleared("ng_in_commit");
        tick(6);
        check("ng_in_commit_after", bus.square, 9'h000);
        bus.mouse_left = 1'b0;
        tick(4);

        click(12'd344, 12'd259, 1'b1, 4'd5, 0);
        pulse_new_game();

        // Blue 1,2,3 against yellow 5,9.
        move(1); move(5); move(2); move(9); move(3);
`ifdef BOARD_WIN_DETECT_EN
        check("win_game_over", bus.game_over, 1'b1);
        check("win_winner", bus.winner, 2'b01);
        click(sq_x(4), sq_y(4), 1'b0, 4'd0, 0);
`else
        check("win_game_over", bus.game_over, 1'b0);
        check("win_winner", bus.winner, 2'b00);
`endif
        pulse_new_game();

        // Full board with no line: draw in either build.
        move(1); move(2); move(3); move(5); move(4);
        move(6); move(8); move(7); move(9);
        check("draw_game_over", bus.game_over, 1'b1);
        check("draw_winner", bus.winner, 2'b11);
        pulse_new_game();

        // Reset while in DECODE wipes the board and drops the pending move.
        move(5);
        bus.mouse_xpos = sq_x(1);
        bus.mouse_ypos = sq_y(1);
        bus.mouse_left = 1'b1;
        tick(3);
        rst = 1'b1;
        bus.mouse_left = 1'b0;
        tick(1);
        rst = 1'b0;
        exp_sq = '0; exp_col = '0; exp_turn = 1'b0;
        check_cleared("rst_decode");
        tick(8);
        check("rst_decode_after", bus.square, 9'h000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/board_select_ctl.md
BOARD_SELECT_CTL -- requirements
Module: board_select_ctl

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, meaning flip-flop depth of the mouse_left synchroniser (legal 2..3).
REQ-002 SHALL have pclk  input  1  pixel clock; all logic on rising edge.
REQ-003 SHALL have rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have mouse_xpos  input  12  cursor x in pixels.
REQ-005 SHALL have mouse_ypos  input  12  cursor y in pixels.
REQ-006 SHALL have mouse_left  input  1  left button level, asynchronous.
REQ-007 SHALL have start_en / choice_en  input  1 each  game running / colour-choice menu active.
REQ-008 SHALL have new_game  input  1  one-cycle board clear request.
REQ-009 SHALL have square  output  9  occupied flags, bit i = square i+1 (feeds per-square draw stages).
REQ-010 SHALL have square_color  output  9  owner per square, 0 = blue, 1 = yellow.
REQ-011 SHALL have turn  output  1  colour of next move; move_valid  output  1  one-cycle commit pulse; move_idx  output  4  committed square 1..9.
REQ-012 SHALL have game_over  output  1  and winner  output  2  (00 none, 01 blue, 10 yellow, 11 draw).

Function
REQ-013 SHALL synchronise mouse_left through SYNC_STAGES flops and detect press as rising edge of the synchronised level.
REQ-014 SHALL decode grid columns x 8..343, 344..679, 680..1015 and rows y 10..258, 259..507, 508..756, bounds inclusive; square = row*3 + col + 1; outside all ranges = index 0 (miss).
REQ-015 SHALL implement FSM IDLE, WAIT_PRESS, DECODE, COMMIT, WAIT_RELEASE.
REQ-016 IDLE -> WAIT_PRESS when start_en=1 and choice_en=0 and game_over=0; any state -> IDLE when that condition drops, board retained.
REQ-017 WAIT_PRESS -> DECODE on press edge, capturing mouse_xpos/ypos into registers that cycle.
REQ-018 DECODE SHALL register the square index; -> COMMIT if index nonzero and square[index-1]=0, else -> WAIT_RELEASE without change.
REQ-019 COMMIT SHALL set square[idx-1]=1, square_color[idx-1]=turn, toggle turn, load move_idx, pulse move_valid for exactly one cycle, then -> WAIT_RELEASE.
REQ-020 Latency: outputs update on the 2nd rising edge after the edge where the press is detected.
REQ-021 WAIT_RELEASE -> WAIT_PRESS only when synchronised button is low; held button SHALL never produce a second move.
REQ-022 new_game SHALL clear square, square_color, turn, move_idx, game_over, winner and force IDLE next cycle; new_game wins over a same-cycle COMMIT.
REQ-023 Once game_over=1, presses SHALL be ignored until new_game or rst.
REQ-024 move_valid SHALL be 0 in every cycle other than the COMMIT cycle.

Reset
REQ-025 On rst: square=0, square_color=0, turn=0 (blue first), move_valid=0, move_idx=0, game_over=0, winner=00, synchroniser flops=0, FSM=IDLE.
REQ-026 rst mid-operation SHALL abort any pending decode/commit with no partial board update.

Configuration
REQ-027 With BOARD_WIN_DETECT_EN defined: the cycle after COMMIT, 8 lines (3 rows, 3 columns, 2 diagonals) SHALL be checked; three same-colour occupied squares -> game_over=1, winner=01/10; else board full -> game_over=1, winner=11.
REQ-028 Without BOARD_WIN_DETECT_EN: game_over=1, winner=11 only when all 9 squares occupied; 01/10 never produced.

Structure
REQ-029 Shared package ttt_pkg SHALL hold grid x/y bounds, FSM state enum, colour codes (0 blue, 1 yellow) and winner codes.
REQ-030 Position-to-index decode SHALL be sub-module square_decode (combinational, 12-bit x/y in, 4-bit index out).

Verification
REQ-031 start_en=1, choice_en=0, cursor (500,400), click -> move_valid pulse, move_idx=5, square[4]=1, square_color[4]=0, turn=1, 2 cycles after detected edge.
REQ-032 Second click at (500,400) -> no move_valid, turn stays 1; click at boundary (343,258) -> move_idx=1, (344,259) -> move_idx=5.
REQ-033 Click at (1016,400) or with choice_en=1 -> no board change; button held 1000 cycles -> exactly one move.
REQ-034 Blue 1,2,3 interleaved with yellow 5,9 -> with macro game_over=1, winner=01, next click ignored; without macro game_over=0.
REQ-035 new_game asserted in COMMIT cycle -> board all 0, turn=0, no move recorded; rst mid-DECODE -> all outputs at reset values.
